// File: rtl/regfile_bypass.sv
// Multi-ported register file: one write port, two read ports with same-cycle
// write-through bypass, an optional hardwired-zero entry 0 and an optional
// registered read stage.
module regfile_bypass #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int READ_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re1,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic             re2,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2,
    output logic             wr_zero_hit
);

    localparam bit ZeroEn = (ZERO_REG != 0);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_zero;
    logic             wr_en;
    logic             wr_zero_hit_q;
    logic [WIDTH-1:0] rd1_comb;
    logic [WIDTH-1:0] rd2_comb;

    // A write aimed at a hardwired-zero entry 0 is flagged but never stored.
    assign wr_zero = we && ZeroEn && (waddr == '0);
    assign wr_en   = we && !wr_zero;

    // Storage array; cleared asynchronously, written on rising clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Records that the previous cycle's write was swallowed by entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_zero_hit_q <= 1'b0;
        end else begin
            wr_zero_hit_q <= wr_zero;
        end
    end

    assign wr_zero_hit = wr_zero_hit_q;

    // Port 1 combinational view: array, then bypass, then zero/reset override.
    always_comb begin
        rd1_comb = mem_q[raddr1];
        if (we && (waddr == raddr1)) begin
            rd1_comb = wdata;
        end
        // Overrides last so entry 0 never bypasses and reset forces 0.
        if (rst || (ZeroEn && (raddr1 == '0))) begin
            rd1_comb = '0;
        end
    end

    // Port 2 combinational view, identical rules to port 1.
    always_comb begin
        rd2_comb = mem_q[raddr2];
        if (we && (waddr == raddr2)) begin
            rd2_comb = wdata;
        end
        if (rst || (ZeroEn && (raddr2 == '0))) begin
            rd2_comb = '0;
        end
    end

    if (READ_REG != 0) begin : g_rd_reg
        logic [WIDTH-1:0] rdata1_q;
        logic [WIDTH-1:0] rdata2_q;

        // Registered read: capture the bypassed view when enabled, else hold.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata1_q <= '0;
                rdata2_q <= '0;
            end else begin
                if (re1) begin
                    rdata1_q <= rd1_comb;
                end
                if (re2) begin
                    rdata2_q <= rd2_comb;
                end
            end
        end

        assign rdata1 = rdata1_q;
        assign rdata2 = rdata2_q;
    end else begin : g_rd_comb
        // Read enables only matter for the registered variant.
        logic unused_re;
        assign unused_re = re1 ^ re2;
        assign rdata1    = rd1_comb;
        assign rdata2    = rd2_comb;
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: four parameterisations share one stimulus stream
// and are compared every cycle against a behavioural array model.
module tb_regfile_bypass;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic        re1 = 1'b0;
    logic        re2 = 1'b0;
    logic [4:0]  waddr = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] wdata = '0;

    logic [31:0] o1_0, o2_0, o1_1, o2_1, o1_2, o2_2;
    logic [15:0] o1_3, o2_3;
    logic        z_0, z_1, z_2, z_3;

    int tests = 0;
    int fails = 0;

    // Model state per instance.
    logic [31:0] mdl_mem [N][32];
    logic [31:0] mdl_rq1 [N];
    logic [31:0] mdl_rq2 [N];
    logic        mdl_hit [N];

    always #5 clk = ~clk;

    // u0: defaults, u1: ordinary entry 0, u2: registered read, u3: 16x8.
    regfile_bypass u0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(o1_0),
        .re2(re2), .raddr2(raddr2), .rdata2(o2_0), .wr_zero_hit(z_0)
    );
    regfile_bypass #(.ZERO_REG(0)) u1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(o1_1),
        .re2(re2), .raddr2(raddr2), .rdata2(o2_1), .wr_zero_hit(z_1)
    );
    regfile_bypass #(.READ_REG(1)) u2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(o1_2),
        .re2(re2), .raddr2(raddr2), .rdata2(o2_2), .wr_zero_hit(z_2)
    );
    regfile_bypass #(.WIDTH(16), .DEPTH(8)) u3 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr[2:0]), .wdata(wdata[15:0]),
        .re1(re1), .raddr1(raddr1[2:0]), .rdata1(o1_3),
        .re2(re2), .raddr2(raddr2[2:0]), .rdata2(o2_3), .wr_zero_hit(z_3)
    );

    function automatic int depth_of(int i);
        return (i == 3) ? 8 : 32;
    endfunction

    function automatic bit zero_of(int i);
        return i != 1;
    endfunction

    function automatic bit rreg_of(int i);
        return i == 2;
    endfunction

    function automatic logic [31:0] mask_of(int i);
        return (i == 3) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] act_rd(int i, int p);
        case (i)
            0: return (p == 1) ? o1_0 : o2_0;
            1: return (p == 1) ? o1_1 : o2_1;
            2: return (p == 1) ? o1_2 : o2_2;
            default: return (p == 1) ? {16'h0, o1_3} : {16'h0, o2_3};
        endcase
    endfunction

    function automatic logic act_hit(int i);
        case (i)
            0: return z_0;
            1: return z_1;
            2: return z_2;
            default: return z_3;
        endcase
    endfunction

    // What a read of address a sees right now, from the current inputs.
    function automatic logic [31:0] comb_read(int i, logic [4:0] a);
        int d  = depth_of(i);
        int aa = int'(a) % d;
        int wa = int'(waddr) % d;
        if (rst) return 32'h0;
        if (zero_of(i) && aa == 0) return 32'h0;
        if (we && wa == aa) return wdata & mask_of(i);
        return mdl_mem[i][aa];
    endfunction

    function automatic logic [31:0] exp_rd(int i, int p);
        if (rreg_of(i)) return (p == 1) ? mdl_rq1[i] : mdl_rq2[i];
        return (p == 1) ? comb_read(i, raddr1) : comb_read(i, raddr2);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < 32; a++) mdl_mem[i][a] = 32'h0;
            mdl_rq1[i] = 32'h0;
            mdl_rq2[i] = 32'h0;
            mdl_hit[i] = 1'b0;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d rdata1", i), act_rd(i, 1), exp_rd(i, 1));
            chk($sformatf("u%0d rdata2", i), act_rd(i, 2), exp_rd(i, 2));
            chk($sformatf("u%0d wr_zero_hit", i), {31'h0, act_hit(i)}, {31'h0, mdl_hit[i]});
        end
    endtask

    // Apply one cycle's inputs after the falling edge and check outputs.
    task automatic drive(input logic r, input logic w, input int wa, input logic [31:0] wd,
                         input logic e1, input int a1, input logic e2, input int a2);
        @(negedge clk);
        rst    = r;
        if (r) model_clear();
        we     = w;
        waddr  = 5'(wa);
        wdata  = wd;
        re1    = e1;
        raddr1 = 5'(a1);
        re2    = e2;
        raddr2 = 5'(a2);
        #2;
        compare_all();
    endtask

    // Advance the model across a rising edge using the held inputs.
    task automatic step();
        logic [31:0] r1, r2;
        int wa;
        bit zsup;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                for (int a = 0; a < 32; a++) mdl_mem[i][a] = 32'h0;
                mdl_rq1[i] = 32'h0;
                mdl_rq2[i] = 32'h0;
                mdl_hit[i] = 1'b0;
            end else begin
                r1 = comb_read(i, raddr1);
                r2 = comb_read(i, raddr2);
                if (rreg_of(i) && re1) mdl_rq1[i] = r1;
                if (rreg_of(i) && re2) mdl_rq2[i] = r2;
                wa   = int'(waddr) % depth_of(i);
                zsup = zero_of(i) && wa == 0;
                mdl_hit[i] = we && zsup;
                if (we && !zsup) mdl_mem[i][wa] = wdata & mask_of(i);
            end
        end
    endtask

    initial begin
        int wa, a1, a2;
        model_clear();
        repeat (2) @(posedge clk);

        // Under reset a bypassing write must not reach the outputs.
        drive(1, 1, 4, 32'h1234_5678, 1, 4, 1, 4);
        chk("reset bypass blocked", o1_0, 32'h0);
        chk("reset hit", {31'h0, z_0}, 32'h0);
        step();

        // Release; the write on the first edge must land.
        drive(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 32'h0, 1, 5, 1, 6);
        chk("lit read entry 5", o1_0, 32'hDEAD_BEEF);
        chk("lit read entry 6", o2_0, 32'h0);
        step();

        // Same-cycle write-through on both ports.
        drive(0, 1, 7, 32'h1234_5678, 0, 7, 0, 7);
        chk("lit bypass port1", o1_0, 32'h1234_5678);
        chk("lit bypass port2", o2_0, 32'h1234_5678);
        step();

        // Entry 0 suppression vs ordinary entry 0.
        drive(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("lit zero no bypass", o1_0, 32'h0);
        step();
        drive(0, 0, 0, 32'h0, 0, 0, 0, 0);
        chk("lit zero after edge", o1_0, 32'h0);
        chk("lit zero hit set", {31'h0, z_0}, 32'h1);
        chk("lit ordinary entry 0", o1_1, 32'hFFFF_FFFF);
        chk("lit ordinary no hit", {31'h0, z_1}, 32'h0);
        step();
        drive(0, 1, 3, 32'hA5A5_A5A5, 0, 3, 0, 0);
        chk("lit zero hit one cycle", {31'h0, z_0}, 32'h0);
        step();

        // Registered read: load one edge later, then hold with re1=0.
        drive(0, 0, 0, 32'h0, 1, 3, 0, 0);
        chk("lit reg read before edge", o1_2, 32'hDEAD_BEEF);
        step();
        drive(0, 0, 0, 32'h0, 0, 4, 0, 0);
        chk("lit reg read loaded", o1_2, 32'hA5A5_A5A5);
        step();
        drive(0, 0, 0, 32'h0, 0, 4, 0, 0);
        chk("lit reg read holds", o1_2, 32'hA5A5_A5A5);
        step();

        // Narrow instance and aliasing sweep.
        drive(0, 1, 7, 32'h0000_BEEF, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 32'h0, 1, 7, 1, 7);
        chk("lit narrow port1", {16'h0, o1_3}, 32'h0000_BEEF);
        chk("lit narrow port2", {16'h0, o2_3}, 32'h0000_BEEF);
        step();
        for (int a = 0; a < 32; a++) begin
            drive(0, 1, a, {11'h0, 5'(a), 11'h7FF, 5'(31 - a)}, 0, 0, 0, 0);
            step();
        end
        for (int a = 0; a < 32; a++) begin
            drive(0, 0, 0, 32'h0, 1, a, 1, 31 - a);
            step();
        end

        // Fill with index values, then pulse reset between edges.
        for (int a = 1; a < 32; a++) begin
            drive(0, 1, a, a, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 32'h0, 1, 5, 1, 31);
        step();
        drive(0, 0, 0, 32'h0, 0, 5, 0, 31);
        chk("lit pre-reset entry 5", o1_0, 32'h5);
        rst = 1'b1;
        model_clear();
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("lit async clear u%0d rdata1", i), act_rd(i, 1), 32'h0);
            chk($sformatf("lit async clear u%0d rdata2", i), act_rd(i, 2), 32'h0);
        end
        compare_all();
        rst = 1'b0;
        step();

        // Reset in the same cycle as a write wins.
        drive(0, 1, 9, 32'h1111_1111, 0, 0, 0, 0);
        step();
        drive(0, 1, 9, 32'h2222_2222, 0, 0, 0, 0);
        rst = 1'b1;
        model_clear();
        #1;
        step();
        drive(0, 0, 0, 32'h0, 1, 9, 1, 9);
        chk("lit reset beats write", o1_0, 32'h0);
        step();

        // Randomised traffic with frequent address collisions.
        for (int k = 0; k < 800; k++) begin
            wa = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : int'($urandom_range(0, 31));
            drive(($urandom_range(0, 79) == 0), $urandom_range(0, 1) == 1, wa, $urandom,
                  $urandom_range(0, 1) == 1, a1, $urandom_range(0, 1) == 1, a2);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 Parameter WIDTH, default 32: data width of every entry and data port.
REQ-002 Parameter DEPTH, default 32: number of entries; SHALL be a power of two, >= 2.
REQ-003 Parameter AW, default $clog2(DEPTH): address width.
REQ-004 Parameter ZERO_REG, default 1: 1 = entry 0 hardwired to zero; 0 = entry 0 ordinary.
REQ-005 Parameter READ_REG, default 0: 0 = combinational read; 1 = registered read, 1-cycle latency.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 we  input  1  write enable.
REQ-009 waddr  input  AW  write address.
REQ-010 wdata  input  WIDTH  write data.
REQ-011 re1  input  1  read-port-1 enable; used only when READ_REG=1.
REQ-012 raddr1  input  AW  read-port-1 address.
REQ-013 rdata1  output  WIDTH  read-port-1 data.
REQ-014 re2  input  1  read-port-2 enable; used only when READ_REG=1.
REQ-015 raddr2  input  AW  read-port-2 address.
REQ-016 rdata2  output  WIDTH  read-port-2 data.
REQ-017 wr_zero_hit  output  1  registered flag: last accepted write targeted entry 0 while ZERO_REG=1.

Function
REQ-018 Write: on rising clk with we=1 and rst=0, entry[waddr] SHALL take wdata.
REQ-019 With ZERO_REG=1, a write to waddr=0 SHALL NOT change entry 0; entry 0 SHALL always read 0.
REQ-020 wr_zero_hit SHALL be 1 for the cycle after a write with we=1, waddr=0, ZERO_REG=1; otherwise 0.
REQ-021 READ_REG=0: rdataN SHALL equal entry[raddrN] combinationally.
REQ-022 READ_REG=0 bypass: if we=1, waddr=raddrN, and the address is not a zero-suppressed entry 0, rdataN SHALL equal wdata in the same cycle (write-through; replaces a falling-edge write).
REQ-023 READ_REG=1: on rising clk with reN=1, rdataN SHALL load the value REQ-021/022 would give that cycle, including same-cycle bypass of wdata.
REQ-024 READ_REG=1 with reN=0: rdataN SHALL hold its previous value.
REQ-025 Both read ports SHALL be independent; raddr1=raddr2 SHALL return identical data.
REQ-026 With ZERO_REG=1, a read of address 0 SHALL return 0 even when we=1, waddr=0 in the same cycle (no bypass).
REQ-027 Out-of-range addresses are impossible (power-of-two DEPTH); no address checking is required.
REQ-028 No other state exists; single write port, so no write-write conflicts.

Reset
REQ-029 rst=1 SHALL immediately, without a clock edge, clear every entry, registered rdata1/rdata2 (READ_REG=1) and wr_zero_hit to 0.
REQ-030 While rst=1, writes and registered reads SHALL be ignored; READ_REG=0 outputs SHALL read 0.
REQ-031 Deassertion of rst SHALL take effect at the next rising clk; a we=1 on that edge SHALL be accepted.
REQ-032 Reset asserted mid-write (same cycle as we=1) SHALL win; the entry SHALL read 0 afterwards.

Verification
REQ-033 Default params: write 0xDEADBEEF to entry 5, next cycle raddr1=5 -> rdata1=0xDEADBEEF; raddr2=6 -> 0.
REQ-034 Bypass, READ_REG=0: we=1, waddr=7, wdata=0x12345678, raddr1=raddr2=7 same cycle -> both rdata=0x12345678 before the edge.
REQ-035 Zero reg: write 0xFFFFFFFF to waddr=0, raddr1=0 -> rdata1=0 same and next cycle; wr_zero_hit=1 for one cycle; with ZERO_REG=0 -> rdata1=0xFFFFFFFF after the edge.
REQ-036 READ_REG=1: re1=1, raddr1=3 (entry 3 = 0xA5A5A5A5) -> rdata1 updates one edge later; then re1=0, raddr1=4 -> rdata1 holds 0xA5A5A5A5.
REQ-037 Async reset: fill entries 1..31 with the index value, pulse rst between clock edges -> all reads 0 immediately, registered outputs 0 without a clock.
REQ-038 WIDTH=16, DEPTH=8: write 0xBEEF to entry 7, read both ports -> 0xBEEF; writes to every address do not alias.
